alu_zba_arbiter: RTL and testbench
==================================

Name: alu_zba_arbiter

Overview:
Shares one combinational Zba ALU instance between two requesters. Port 0 is the execute-stage integer pipe; port 1 is the address-generation/auxiliary unit. Each requester gets a valid/ready request channel and a one-entry registered response channel. The block drives the ALU operand and control inputs and captures the ALU result with a round-robin arbitration policy. It sits beside the ALU in the EX stage.

Parameters:
TAG_W, 4, width of the requester-supplied tag returned with each response.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; discards held responses and blocks grants this cycle
reqN_valid  in  1  request valid (N = 0,1)
reqN_ready  out  1  request accepted when valid & ready (combinational)
reqN_a  in  64  operand A
reqN_b  in  64  operand B
reqN_ctrl  in  4  ALU control code
reqN_tag  in  TAG_W  requester tag
rspN_valid  out  1  response valid
rspN_ready  in  1  response consumed when valid & ready
rspN_result  out  64  captured ALU result
rspN_zero  out  1  captured zero flag
rspN_tag  out  TAG_W  tag of the request
rspN_err  out  1  illegal-opcode flag (see Optional Feature)
alu_src_a  out  64  to ALU SrcA
alu_src_b  out  64  to ALU SrcB
alu_ctrl  out  4  to ALU ALUControl
alu_result  in  64  from ALU ALUResult
alu_zero  in  1  from ALU Zero

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset: rspN_valid=0, rspN_result=0, rspN_zero=0, rspN_tag=0, rspN_err=0, and rr_ptr=0.
- Eligibility: requester N is eligible when reqN_valid=1, flush=0, and its response slot is free. A slot is free when it is empty or being drained this cycle (rspN_valid & rspN_ready).
- Arbitration:
  - Only one eligible requester: it wins.
  - Both eligible: the requester at rr_ptr wins.
  - After any grant, rr_ptr becomes the index of the other requester.
  - With no grant, rr_ptr holds.
- Handshake outputs: reqN_ready = grant to N. reqN_ready is never asserted for a requester that is not eligible, and depends on reqN_valid.
- ALU drive:
  - During a grant cycle, alu_src_a, alu_src_b and alu_ctrl are the winner's reqN_a, reqN_b and reqN_ctrl.
  - With no grant, all three are 0 (ALU computes ADD 0+0).
- Latency: a request accepted in cycle k produces rspN_valid=1 from cycle k+1. On the edge ending cycle k, rspN_result/zero/tag are loaded from alu_result, alu_zero and reqN_tag.
- Response hold: while rspN_valid=1 and rspN_ready=0, all rspN_* outputs are held stable.
- Drain without refill: if the response drains in a cycle with no new grant to N, rspN_valid drops to 0 at the next edge.
- Throughput: with no contention and a continuously ready consumer, each port sustains 1 op/cycle. Under continuous contention, grants strictly alternate.
- Backpressure isolation: a stalled rsp0 never blocks port 1, and vice versa.
- Flush:
  - In a flush cycle, no grant occurs and both reqN_ready=0.
  - At the next edge both rspN_valid clear, even if rspN_ready was high.
  - rr_ptr holds.
- Reset mid-operation: held responses are discarded immediately on reset assertion. The first cycle after deassertion behaves as after power-up.
- Arithmetic: the block performs no arithmetic; results are the ALU's 64-bit values unmodified.

Optional Feature:
Macro ALU_ZBA_ARB_OPCHK_EN.
- Defined:
  - ctrl codes 4'b1100 to 4'b1111 are illegal.
  - An illegal request is still granted and handshaken normally and still occupies the ALU slot.
  - Its response has rspN_err=1, rspN_result=0, rspN_zero=1.
  - Legal codes give rspN_err=0.
- Undefined: rspN_err is constant 0, and results for all codes are passed through from the ALU unchanged.

Test Plan:
- Basic op: req0 a=3, b=100, ctrl=4'b0101, rsp0_ready=1 -> rsp0 valid next cycle, result=112, zero=0, tag echoed. Then a=0x0000_0000_FFFF_FFFF, b=1, ctrl=4'b0000 -> 0x1_0000_0000.
- Contention: after reset, both ports valid every cycle with ready consumers -> grants 0,1,0,1. First add.uw on port 1 (a=0xFFFF_FFFF_0000_0005, b=1, ctrl=4'b0111) returns 6.
- Backpressure: rsp0_ready=0 with rsp0 full, req0 and req1 valid -> req0_ready=0 and port 1 granted each cycle. Raise rsp0_ready -> port 0 is granted in the same cycle and the new result is visible next cycle.
- Flush: both responses held, flush=1 for one cycle with both reqs valid -> no grants that cycle, both rspN_valid=0 after the edge, rr_ptr unchanged.
- Reset mid-stream: assert rst_n=0 asynchronously mid-cycle with rsp1_valid=1 -> rsp1_valid=0 immediately. After release, simultaneous requests grant port 0 first.
- OPCHK (macro defined): req1 ctrl=4'b1110 -> handshake completes, rsp1_err=1, result=0, zero=1. With the macro undefined, the same request gives rsp1_err=0, result=0, zero=1 (ALU default).

Source files
------------

// File: rtl/alu_zba_arbiter.sv
// Two-port round-robin arbiter in front of one shared Zba ALU, with registered responses.
// Build option: define ALU_ZBA_ARB_OPCHK_EN to flag ctrl codes 4'b11xx as illegal.
module alu_zba_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_a,
    input  logic [63:0]      req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_a,
    input  logic [63:0]      req1_b,
    input  logic [3:0]       req1_ctrl,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [63:0]      rsp0_result,
    output logic             rsp0_zero,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [63:0]      rsp1_result,
    output logic             rsp1_zero,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             rsp1_err,

    output logic [63:0]      alu_src_a,
    output logic [63:0]      alu_src_b,
    output logic [3:0]       alu_ctrl,
    input  logic [63:0]      alu_result,
    input  logic             alu_zero
);

    logic             r_rr_ptr;

    logic             r_vld0;
    logic [63:0]      r_res0;
    logic             r_zero0;
    logic [TAG_W-1:0] r_tag0;

    logic             r_vld1;
    logic [63:0]      r_res1;
    logic             r_zero1;
    logic [TAG_W-1:0] r_tag1;

    logic             w_free0;
    logic             w_free1;
    logic             w_elig0;
    logic             w_elig1;
    logic             w_gnt0;
    logic             w_gnt1;

    logic [63:0]      w_ld_res0;
    logic             w_ld_zero0;
    logic [63:0]      w_ld_res1;
    logic             w_ld_zero1;

    // A slot draining this cycle can take a new result on the same edge.
    assign w_free0 = !r_vld0 || rsp0_ready;
    assign w_free1 = !r_vld1 || rsp1_ready;

    assign w_elig0 = req0_valid && !flush && w_free0;
    assign w_elig1 = req1_valid && !flush && w_free1;

    assign w_gnt0 = w_elig0 && (!w_elig1 || (r_rr_ptr == 1'b0));
    assign w_gnt1 = w_elig1 && (!w_elig0 || (r_rr_ptr == 1'b1));

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        alu_src_a = '0;
        alu_src_b = '0;
        alu_ctrl  = '0;
        unique case (1'b1)
            w_gnt0: begin
                alu_src_a = req0_a;
                alu_src_b = req0_b;
                alu_ctrl  = req0_ctrl;
            end
            w_gnt1: begin
                alu_src_a = req1_a;
                alu_src_b = req1_b;
                alu_ctrl  = req1_ctrl;
            end
            default: ;
        endcase
    end

`ifdef ALU_ZBA_ARB_OPCHK_EN
    logic w_ill0;
    logic w_ill1;
    logic r_err0;
    logic r_err1;

    assign w_ill0 = (req0_ctrl[3:2] == 2'b11);
    assign w_ill1 = (req1_ctrl[3:2] == 2'b11);

    // Illegal ops still consume the ALU slot but report a forced zero result.
    assign w_ld_res0  = w_ill0 ? 64'd0 : alu_result;
    assign w_ld_zero0 = w_ill0 || alu_zero;
    assign w_ld_res1  = w_ill1 ? 64'd0 : alu_result;
    assign w_ld_zero1 = w_ill1 || alu_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            if (w_gnt0) r_err0 <= w_ill0;
            if (w_gnt1) r_err1 <= w_ill1;
        end
    end

    assign rsp0_err = r_err0;
    assign rsp1_err = r_err1;
`else
    assign w_ld_res0  = alu_result;
    assign w_ld_zero0 = alu_zero;
    assign w_ld_res1  = alu_result;
    assign w_ld_zero1 = alu_zero;

    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld0  <= 1'b0;
            r_res0  <= '0;
            r_zero0 <= 1'b0;
            r_tag0  <= '0;
        end else if (flush) begin
            r_vld0 <= 1'b0;
        end else if (w_gnt0) begin
            r_vld0  <= 1'b1;
            r_res0  <= w_ld_res0;
            r_zero0 <= w_ld_zero0;
            r_tag0  <= req0_tag;
        end else if (rsp0_ready) begin
            r_vld0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1  <= 1'b0;
            r_res1  <= '0;
            r_zero1 <= 1'b0;
            r_tag1  <= '0;
        end else if (flush) begin
            r_vld1 <= 1'b0;
        end else if (w_gnt1) begin
            r_vld1  <= 1'b1;
            r_res1  <= w_ld_res1;
            r_zero1 <= w_ld_zero1;
            r_tag1  <= req1_tag;
        end else if (rsp1_ready) begin
            r_vld1 <= 1'b0;
        end
    end

    assign rsp0_valid  = r_vld0;
    assign rsp0_result = r_res0;
    assign rsp0_zero   = r_zero0;
    assign rsp0_tag    = r_tag0;

    assign rsp1_valid  = r_vld1;
    assign rsp1_result = r_res1;
    assign rsp1_zero   = r_zero1;
    assign rsp1_tag    = r_tag1;

endmodule

// File: tb/tb_alu_zba_arbiter.sv
// Bench for alu_zba_arbiter: directed scenarios then random traffic vs a slot/round-robin model.
// Honours ALU_ZBA_ARB_OPCHK_EN the same way the design does.
module tb_alu_zba_arbiter;

    logic clk;
    logic rst_n;
    logic flush;

    logic [1:0]       v;
    logic [1:0]       rr;
    logic [1:0][63:0] a;
    logic [1:0][63:0] b;
    logic [1:0][3:0]  c;
    logic [1:0][3:0]  t;

    logic [1:0]       rdy;
    logic [1:0]       rv;
    logic [1:0][63:0] rres;
    logic [1:0]       rz;
    logic [1:0][3:0]  rtag;
    logic [1:0]       rerr;

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_c;
    logic [63:0] alu_res;
    logic        alu_z;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]       m_vld;
    logic [1:0][63:0] m_res;
    logic [1:0]       m_zero;
    logic [1:0][3:0]  m_tag;
    logic [1:0]       m_err;
    int               m_rr;
    logic [1:0]       obs_g;

    alu_zba_arbiter #(.TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_a(a[0]),
        .req0_b(b[0]), .req0_ctrl(c[0]), .req0_tag(t[0]),
        .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_a(a[1]),
        .req1_b(b[1]), .req1_ctrl(c[1]), .req1_tag(t[1]),
        .rsp0_valid(rv[0]), .rsp0_ready(rr[0]), .rsp0_result(rres[0]),
        .rsp0_zero(rz[0]), .rsp0_tag(rtag[0]), .rsp0_err(rerr[0]),
        .rsp1_valid(rv[1]), .rsp1_ready(rr[1]), .rsp1_result(rres[1]),
        .rsp1_zero(rz[1]), .rsp1_tag(rtag[1]), .rsp1_err(rerr[1]),
        .alu_src_a(alu_a), .alu_src_b(alu_b), .alu_ctrl(alu_c),
        .alu_result(alu_res), .alu_zero(alu_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Zba ALU standing in for the real one.
    function automatic logic [63:0] zba(input logic [63:0] x,
                                        input logic [63:0] y,
                                        input logic [3:0] op);
        logic [63:0] xu;
        xu = {32'd0, x[31:0]};
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return (x << 1) + y;
            4'd5:    return (x << 2) + y;
            4'd6:    return (x << 3) + y;
            4'd7:    return xu + y;
            4'd8:    return (xu << 1) + y;
            4'd9:    return (xu << 2) + y;
            4'd10:   return (xu << 3) + y;
            4'd11:   return xu << y[5:0];
            default: return 64'd0;
        endcase
    endfunction

    always_comb begin
        alu_res = zba(alu_a, alu_b, alu_c);
        alu_z   = (alu_res == 64'd0);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_vld  = '0;
        m_res  = '0;
        m_zero = '0;
        m_tag  = '0;
        m_err  = '0;
        m_rr   = 0;
    endtask

    // Entered at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic [1:0]       el;
        logic [1:0]       g;
        int               win;
        logic [1:0]       nv;
        logic [1:0][63:0] nres;
        logic [1:0]       nz;
        logic [1:0][3:0]  ntag;
        logic [1:0]       nerr;
        logic [63:0]      r;
        #2;
        for (int n = 0; n < 2; n++)
            el[n] = v[n] && !flush && (!m_vld[n] || rr[n]);
        win = -1;
        if (el == 2'b11) win = m_rr;
        else if (el[0]) win = 0;
        else if (el[1]) win = 1;
        g = '0;
        if (win >= 0) g[win] = 1'b1;
        obs_g = rdy;
        chk("req_ready", {62'd0, rdy}, {62'd0, g});
        chk("alu_src_a", alu_a, (win >= 0) ? a[win] : 64'd0);
        chk("alu_src_b", alu_b, (win >= 0) ? b[win] : 64'd0);
        chk("alu_ctrl", {60'd0, alu_c}, (win >= 0) ? {60'd0, c[win]} : 64'd0);
        for (int n = 0; n < 2; n++) begin
            chk("rsp_valid", {63'd0, rv[n]}, {63'd0, m_vld[n]});
            if (m_vld[n]) begin
                chk("rsp_result", rres[n], m_res[n]);
                chk("rsp_zero", {63'd0, rz[n]}, {63'd0, m_zero[n]});
                chk("rsp_tag", {60'd0, rtag[n]}, {60'd0, m_tag[n]});
                chk("rsp_err", {63'd0, rerr[n]}, {63'd0, m_err[n]});
            end
        end
        nv = m_vld; nres = m_res; nz = m_zero; ntag = m_tag; nerr = m_err;
        for (int n = 0; n < 2; n++) begin
            if (flush) begin
                nv[n] = 1'b0;
            end else if (g[n]) begin
                r = zba(a[n], b[n], c[n]);
                nv[n] = 1'b1;
                nres[n] = r;
                nz[n] = (r == 64'd0);
                nerr[n] = 1'b0;
                ntag[n] = t[n];
`ifdef ALU_ZBA_ARB_OPCHK_EN
                if (c[n] >= 4'd12) begin
                    nres[n] = 64'd0;
                    nz[n] = 1'b1;
                    nerr[n] = 1'b1;
                end
`endif
            end else if (rr[n]) begin
                nv[n] = 1'b0;
            end
        end
        @(posedge clk);
        m_vld = nv; m_res = nres; m_zero = nz; m_tag = ntag; m_err = nerr;
        if (win >= 0) m_rr = 1 - win;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        v = '0; rr = '0; a = '0; b = '0; c = '0; t = '0;
        m_reset();
        #3;
        for (int n = 0; n < 2; n++) begin
            chk("rst_valid", {63'd0, rv[n]}, 64'd0);
            chk("rst_result", rres[n], 64'd0);
            chk("rst_zero", {63'd0, rz[n]}, 64'd0);
            chk("rst_tag", {60'd0, rtag[n]}, 64'd0);
            chk("rst_err", {63'd0, rerr[n]}, 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention straight after reset: 0,1,0,1.
        v = 2'b11; rr = 2'b11;
        a[0] = 64'd10; b[0] = 64'd20; c[0] = 4'd0; t[0] = 4'd1;
        a[1] = 64'hFFFF_FFFF_0000_0005; b[1] = 64'd1; c[1] = 4'd7; t[1] = 4'd2;
        step();
        chk("cont_g0", {62'd0, obs_g}, 64'd1);
        step();
        chk("cont_g1", {62'd0, obs_g}, 64'd2);
        chk("adduw", rres[1], 64'd6);
        step();
        chk("cont_g2", {62'd0, obs_g}, 64'd1);
        step();
        chk("cont_g3", {62'd0, obs_g}, 64'd2);

        // Basic op on port 0.
        v = 2'b01;
        a[0] = 64'd3; b[0] = 64'd100; c[0] = 4'd5; t[0] = 4'd9;
        step();
        chk("basic_sh2add", rres[0], 64'd112);
        chk("basic_tag", {60'd0, rtag[0]}, 64'd9);
        a[0] = 64'h0000_0000_FFFF_FFFF; b[0] = 64'd1; c[0] = 4'd0;
        step();
        chk("basic_add", rres[0], 64'h1_0000_0000);
        v = 2'b00;
        step();

        // Backpressure on port 0 leaves port 1 running.
        rr = 2'b10; v = 2'b01;
        step();
        v = 2'b11;
        for (int i = 0; i < 3; i++) begin
            a[1] = 64'(i + 40); b[1] = 64'd2; c[1] = 4'd4;
            step();
            chk("bp_port1", {62'd0, obs_g}, 64'd2);
        end
        rr = 2'b11;
        a[0] = 64'd7; b[0] = 64'd8; c[0] = 4'd6; t[0] = 4'd3;
        step();
        chk("bp_release", {62'd0, obs_g}, 64'd1);
        chk("bp_result", rres[0], 64'd64);

        // Flush with both responses held.
        rr = 2'b00; v = 2'b11;
        step();
        step();
        flush = 1'b1;
        step();
        chk("flush_nogrant", {62'd0, obs_g}, 64'd0);
        chk("flush_clear", {62'd0, rv}, 64'd0);
        flush = 1'b0; rr = 2'b11;
        step();
        chk("flush_rr", {62'd0, obs_g}, 64'd1);

        // Asynchronous reset while rsp1 is held.
        rr = 2'b00; v = 2'b10;
        step();
        v = 2'b11;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_valid1", {63'd0, rv[1]}, 64'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rr = 2'b11;
        step();
        chk("midrst_first", {62'd0, obs_g}, 64'd1);

        // Illegal-opcode handling on port 1.
        v = 2'b10; c[1] = 4'd14; a[1] = 64'd5; b[1] = 64'd6; t[1] = 4'd11;
        step();
        chk("opchk_hs", {62'd0, obs_g}, 64'd2);
        chk("opchk_result", rres[1], 64'd0);
        chk("opchk_zero", {63'd0, rz[1]}, 64'd1);
`ifdef ALU_ZBA_ARB_OPCHK_EN
        chk("opchk_err", {63'd0, rerr[1]}, 64'd1);
`else
        chk("opchk_err", {63'd0, rerr[1]}, 64'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                v[n]  = ($urandom_range(0, 3) != 0);
                rr[n] = ($urandom_range(0, 3) != 0);
                a[n]  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3))
                                                    : {$urandom, $urandom};
                b[n]  = {$urandom, $urandom};
                c[n]  = 4'($urandom_range(0, 15));
                t[n]  = 4'($urandom_range(0, 15));
                if (c[n] == 4'd1 && $urandom_range(0, 1) == 1) b[n] = a[n];
            end
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
